mem_arbiter: RTL
================

# mem_arbiter

Parametrised N-port memory scheduler between requesters (CPU fetch, CPU data, DMA, video) and a single-port synchronous memory. Arbitrates up to NPORTS outstanding requests, issues at most one memory command per cycle, and routes read data back to the owning port. Holds each requester on WAIT until its access completes. Sits directly above the memory device, where a fixed 2-port scheduler would otherwise go.

## Interface
- NPORTS, 2: requester count, 2..8
- AW, 32: address width
- DW, 16: data width
- MEM_LAT, 1: memory read latency in cycles from the command cycle to valid `memdat`, 1..4
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (port 0 highest)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- REQ  in  NPORTS  request per port
- WRITE  in  NPORTS  1 = write, 0 = read, per port
- ADDR  in  NPORTS*AW  port i address at [i*AW +: AW]
- DAT  in  NPORTS*DW  port i write data at [i*DW +: DW]
- WAIT  out  NPORTS  stall to port i
- ACK  out  NPORTS  one-cycle completion pulse
- OUT  out  DW  read data, valid only with the corresponding ACK bit
- MEMEN  out  1  memory command valid
- MEMWRI  out  1  memory write enable
- MEMADDR  out  AW  memory address
- MEMOUT  out  DW  memory write data
- memdat  in  DW  memory read data

## Operation
- Per-port `pend[i]`: set on grant, cleared on ACK[i]. Port is eligible when REQ[i]=1 and pend[i]=0.
- Requester holds REQ/WRITE/ADDR/DAT stable from assertion until ACK. REQ still high in the ACK cycle is ignored; REQ high in the cycle after ACK is a new request.
- Grant: combinational from eligible set each cycle; at most one grant.
  - PRIO_MODE=0: search starts at `last+1` mod NPORTS; `last` updates to the granted port.
  - PRIO_MODE=1: lowest eligible index wins; `last` is unused.
- Command register: on grant, MEMEN/MEMWRI/MEMADDR/MEMOUT load the granted port's fields; with no grant, MEMEN=0 and MEMWRI=0, with address and data held.
- Writes complete at issue.
- Reads enter a MEM_LAT-deep shift pipe of {valid, port id}. At the pipe exit, `memdat` is registered into OUT, and ACK[id] pulses.
- A write ACK and a read ACK for different ports may coincide; both ACK bits are high. OUT carries the read data.
- WAIT[i] = (REQ[i] | pend[i]) & ~ACK[i], combinational.
- Reset: outputs are 0 (WAIT, ACK, OUT, MEMEN, MEMWRI, MEMADDR, MEMOUT). pend=0, last=NPORTS-1 (port 0 first), and the read pipe is flushed.
- Reset mid-operation: in-flight reads are discarded with no ACK. Requesters must re-issue.

## Timing
- Grant in cycle n leads to MEMEN=1 in cycle n+1.
- Write: ACK in n+1, same cycle as MEMEN.
- Read: `memdat` is valid in n+1+MEM_LAT. OUT and ACK follow in n+2+MEM_LAT; with MEM_LAT=1 that is n+3.
- Throughput: one command per cycle. Each port has at most one outstanding access.
- Round-robin bound: a continuously eligible port is granted within NPORTS cycles. Fixed priority has no bound.

## Structure
- Shared package `mem_pkg`:
  - PRIO_RR / PRIO_FIXED constants
  - MEM_LAT range limits
  - port-id width function clog2(NPORTS)
- Sub-module `rr_arbiter` (NPORTS, PRIO_MODE): inputs eligible vector and `last`; outputs one-hot grant and encoded id. The top level holds the command register, pend bits, read pipe and the WAIT/ACK logic.

## Test plan
- Reset: with rst=1 for 2 cycles, mid-burst, all outputs are 0. The first request after release on ports 0 and 1 together grants port 0.
- Single write: NPORTS=2, port 1 writes ADDR=0x100, DAT=0xBEEF at n. Required: MEMEN=1, MEMWRI=1, MEMADDR=0x100, MEMOUT=0xBEEF at n+1. ACK[1] pulses at n+1, and WAIT[1] falls at n+1.
- Read latency: MEM_LAT=3, port 0 reads 0x20, and the memory model returns 0x1234. Required: OUT=0x1234 with ACK[0] exactly at n+5. WAIT[0] stays high from n to n+4.
- Round-robin fairness: NPORTS=4, all ports requesting continuously, back-to-back reads. Required: grant order 0,1,2,3,0,..., one MEMEN per cycle, no port starved.
- Fixed priority: PRIO_MODE=1 with ports 0 and 2 requesting continuously. Port 2 is granted only in cycles where port 0 is pending or idle.
- Reset during read: MEM_LAT=2, rst asserted one cycle after issue. Required: no ACK or OUT change for the discarded read. A new read after reset returns correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the memory arbiter slice.
// Imported by the arbiter core and its grant logic.
package mem_pkg;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  localparam int NPORTS_MIN = 2;
  localparam int NPORTS_MAX = 8;

  // Port-id width, never below one bit.
  function automatic int clog2(int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the memory arbiter.
// master = requesters, slave = arbiter.
interface mem_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 16
);

  logic [NPORTS-1:0]    REQ;
  logic [NPORTS-1:0]    WRITE;
  logic [NPORTS*AW-1:0] ADDR;
  logic [NPORTS*DW-1:0] DAT;
  logic [NPORTS-1:0]    WAIT;
  logic [NPORTS-1:0]    ACK;
  logic [DW-1:0]        OUT;

  modport master (
    output REQ, WRITE, ADDR, DAT,
    input  WAIT, ACK, OUT
  );

  modport slave (
    input  REQ, WRITE, ADDR, DAT,
    output WAIT, ACK, OUT
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Single-grant picker: round-robin from last+1, or fixed
// priority with port 0 highest.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NPORTS    = 2,
  parameter int PRIO_MODE = PRIO_RR,
  localparam int IW       = clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] elig,
  input  logic [IW-1:0]     last,
  output logic [NPORTS-1:0] gnt,
  output logic [IW-1:0]     gid,
  output logic              gv
);

  int          base;
  int          idx;
  logic [IW-1:0] ix;

  always_comb begin
    gnt  = '0;
    gid  = '0;
    gv   = 1'b0;
    idx  = 0;
    ix   = '0;
    base = (PRIO_MODE == PRIO_FIXED) ? 0 : int'(last) + 1;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (base + k) % NPORTS;
      ix  = IW'(idx);
      if (!gv && elig[ix]) begin
        gv      = 1'b1;
        gid     = ix;
        gnt[ix] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port scheduler in front of a single-port synchronous memory.
// Owns the command register, pend bits, read-return pipe, WAIT/ACK.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NPORTS    = 2,
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  rq,
  output logic          MEMEN,
  output logic          MEMWRI,
  output logic [AW-1:0] MEMADDR,
  output logic [DW-1:0] MEMOUT,
  input  logic [DW-1:0] memdat
);

  localparam int IW = clog2(NPORTS);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX ||
      NPORTS < NPORTS_MIN || NPORTS > NPORTS_MAX) begin : g_bad
    $error("mem_arbiter: parameter out of range");
  end

  logic [NPORTS-1:0] pend;
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] gnt;
  logic [NPORTS-1:0] ack;
  logic [NPORTS-1:0] ack_d;
  logic [IW-1:0]     gid;
  logic [IW-1:0]     last;
  logic [IW-1:0]     cmd_id;
  logic              gv;
  logic [DW-1:0]     out_q;

  logic [MEM_LAT-1:0]         pv;
  logic [MEM_LAT-1:0][IW-1:0] pid;

  assign elig = rq.REQ & ~pend;

  rr_arbiter #(
    .NPORTS    (NPORTS),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .elig (elig),
    .last (last),
    .gnt  (gnt),
    .gid  (gid),
    .gv   (gv)
  );

  // Write ACK lands with the command; read ACK at pipe exit.
  always_comb begin
    ack_d = '0;
    if (gv && rq.WRITE[gid]) ack_d = gnt;
    if (pv[MEM_LAT-1]) ack_d[pid[MEM_LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      ack     <= '0;
      last    <= IW'(NPORTS - 1);
      cmd_id  <= '0;
      pv      <= '0;
      pid     <= '0;
      out_q   <= '0;
      MEMEN   <= 1'b0;
      MEMWRI  <= 1'b0;
      MEMADDR <= '0;
      MEMOUT  <= '0;
    end else begin
      pend   <= (pend | gnt) & ~ack;
      ack    <= ack_d;
      MEMEN  <= gv;
      MEMWRI <= gv & rq.WRITE[gid];
      pv[0]  <= MEMEN & ~MEMWRI;
      pid[0] <= cmd_id;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      if (gv) begin
        MEMADDR <= rq.ADDR[int'(gid)*AW +: AW];
        MEMOUT  <= rq.DAT[int'(gid)*DW +: DW];
        cmd_id  <= gid;
        if (PRIO_MODE == PRIO_RR) last <= gid;
      end
      if (pv[MEM_LAT-1]) out_q <= memdat;
    end
  end

  assign rq.ACK  = ack;
  assign rq.OUT  = out_q;
  assign rq.WAIT = (rq.REQ | pend) & ~ack & {NPORTS{~rst}};

endmodule
